// File: rtl/pipeline_trace_buffer_if.sv
// Decode-side capture, trigger and readback signals of the pipeline trace buffer.
// master drives capture/trigger/read requests, slave is the trace buffer itself.
interface pipeline_trace_buffer_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic            arm_i;
  logic            cap_valid_i;
  logic [XLEN-1:0] cap_pc_i;
  logic [31:0]     cap_instr_i;
  logic [4:0]      cap_rs1_i;
  logic [4:0]      cap_rs2_i;
  logic [4:0]      cap_rd_i;
  logic            trig_en_i;
  logic [XLEN-1:0] trig_pc_i;
  logic            rd_req_i;
  logic [AW-1:0]   rd_idx_i;
  logic            rd_valid_o;
  logic [XLEN-1:0] rd_pc_o;
  logic [31:0]     rd_instr_o;
  logic [4:0]      rd_rs1_o;
  logic [4:0]      rd_rs2_o;
  logic [4:0]      rd_rd_o;
  logic [31:0]     rd_cycle_o;
  logic [1:0]      state_o;
  logic [AW:0]     count_o;

  modport master (
    output arm_i, cap_valid_i, cap_pc_i, cap_instr_i, cap_rs1_i, cap_rs2_i, cap_rd_i,
    output trig_en_i, trig_pc_i, rd_req_i, rd_idx_i,
    input  rd_valid_o, rd_pc_o, rd_instr_o, rd_rs1_o, rd_rs2_o, rd_rd_o, rd_cycle_o,
    input  state_o, count_o
  );

  modport slave (
    input  arm_i, cap_valid_i, cap_pc_i, cap_instr_i, cap_rs1_i, cap_rs2_i, cap_rd_i,
    input  trig_en_i, trig_pc_i, rd_req_i, rd_idx_i,
    output rd_valid_o, rd_pc_o, rd_instr_o, rd_rs1_o, rd_rs2_o, rd_rd_o, rd_cycle_o,
    output state_o, count_o
  );
endinterface

// File: rtl/pipeline_trace_buffer.sv
// Circular decode-stage trace buffer that freezes POST_TRIG captures after a PC-match trigger.
// Optional per-entry cycle stamps are built only when TRACE_CYCLE_STAMP_EN is defined.
module pipeline_trace_buffer #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4
) (
  input logic clk,
  input logic rst,
  pipeline_trace_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] POST_LOAD = CW'(POST_TRIG);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_POST   = 2'd2,
    S_FROZEN = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] post_q, post_d;
  logic          we_s;
  logic          trig_hit_s;
  logic [AW-1:0] wr_ptr_inc_s;
  logic [CW-1:0] count_inc_s;

  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [31:0]     instr_mem_q [DEPTH];
  logic [4:0]      rs1_mem_q   [DEPTH];
  logic [4:0]      rs2_mem_q   [DEPTH];
  logic [4:0]      rd_mem_q    [DEPTH];

  logic            rd_valid_q;
  logic [XLEN-1:0] rd_pc_q;
  logic [31:0]     rd_instr_q;
  logic [4:0]      rd_rs1_q;
  logic [4:0]      rd_rs2_q;
  logic [4:0]      rd_rd_q;
  logic            rd_hit_s;
  logic [AW-1:0]   rd_phys_s;

  assign trig_hit_s   = bus.cap_valid_i & bus.trig_en_i & (bus.cap_pc_i == bus.trig_pc_i);
  assign wr_ptr_inc_s = wr_ptr_q + PTR_ONE;
  // count saturates at DEPTH; the oldest entry is then silently overwritten
  assign count_inc_s  = (count_q == CNT_FULL) ? count_q : (count_q + CNT_ONE);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    post_d   = post_q;
    we_s     = 1'b0;
    if (bus.arm_i) begin
      state_d  = S_ARMED;
      wr_ptr_d = '0;
      count_d  = '0;
      post_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_ARMED: begin
          if (bus.cap_valid_i) begin
            we_s     = 1'b1;
            wr_ptr_d = wr_ptr_inc_s;
            count_d  = count_inc_s;
            if (trig_hit_s) begin
              if (POST_TRIG == 0) begin
                state_d = S_FROZEN;
              end else begin
                state_d = S_POST;
                post_d  = POST_LOAD;
              end
            end else begin
              state_d = S_ARMED;
            end
          end else begin
            state_d = S_ARMED;
          end
        end
        S_POST: begin
          if (bus.cap_valid_i) begin
            we_s     = 1'b1;
            wr_ptr_d = wr_ptr_inc_s;
            count_d  = count_inc_s;
            post_d   = post_q - CNT_ONE;
            if (post_q == CNT_ONE) begin
              state_d = S_FROZEN;
            end else begin
              state_d = S_POST;
            end
          end else begin
            state_d = S_POST;
          end
        end
        S_FROZEN: state_d = S_FROZEN;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      count_q  <= '0;
      post_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      post_q   <= post_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we_s && !rst) begin
      pc_mem_q[wr_ptr_q]    <= bus.cap_pc_i;
      instr_mem_q[wr_ptr_q] <= bus.cap_instr_i;
      rs1_mem_q[wr_ptr_q]   <= bus.cap_rs1_i;
      rs2_mem_q[wr_ptr_q]   <= bus.cap_rs2_i;
      rd_mem_q[wr_ptr_q]    <= bus.cap_rd_i;
    end
  end

  // Reads see the current (pre-arm) pointers, so an arm in the same cycle cannot disturb them
  assign rd_hit_s  = (state_q == S_FROZEN) && ({1'b0, bus.rd_idx_i} < count_q);
  assign rd_phys_s = wr_ptr_q - count_q[AW-1:0] + bus.rd_idx_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_pc_q    <= '0;
      rd_instr_q <= 32'd0;
      rd_rs1_q   <= 5'd0;
      rd_rs2_q   <= 5'd0;
      rd_rd_q    <= 5'd0;
    end else begin
      rd_valid_q <= bus.rd_req_i;
      if (bus.rd_req_i) begin
        if (rd_hit_s) begin
          rd_pc_q    <= pc_mem_q[rd_phys_s];
          rd_instr_q <= instr_mem_q[rd_phys_s];
          rd_rs1_q   <= rs1_mem_q[rd_phys_s];
          rd_rs2_q   <= rs2_mem_q[rd_phys_s];
          rd_rd_q    <= rd_mem_q[rd_phys_s];
        end else begin
          rd_pc_q    <= '0;
          rd_instr_q <= 32'd0;
          rd_rs1_q   <= 5'd0;
          rd_rs2_q   <= 5'd0;
          rd_rd_q    <= 5'd0;
        end
      end
    end
  end

`ifdef TRACE_CYCLE_STAMP_EN
  logic [31:0] cyc_q;
  logic [31:0] cyc_mem_q [DEPTH];
  logic [31:0] rd_cycle_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= 32'd0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (we_s && !rst) begin
      cyc_mem_q[wr_ptr_q] <= cyc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cycle_q <= 32'd0;
    end else if (bus.rd_req_i) begin
      rd_cycle_q <= rd_hit_s ? cyc_mem_q[rd_phys_s] : 32'd0;
    end
  end

  assign bus.rd_cycle_o = rd_cycle_q;
`else
  assign bus.rd_cycle_o = 32'd0;
`endif

  assign bus.rd_valid_o = rd_valid_q;
  assign bus.rd_pc_o    = rd_pc_q;
  assign bus.rd_instr_o = rd_instr_q;
  assign bus.rd_rs1_o   = rd_rs1_q;
  assign bus.rd_rs2_o   = rd_rs2_q;
  assign bus.rd_rd_o    = rd_rd_q;
  assign bus.state_o    = state_q;
  assign bus.count_o    = count_q;
endmodule
